// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C target register responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer chain plus history flop for one bus line; flags rising/falling edges.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging an oversampled SCL/SDA bus to a synchronous 8-bit register port.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | bus free or after STOP
// ADDR        | shifting in the 7-bit address plus R/W bit
// ADDR_ACK    | driving ACK for a matching address
// WR_BYTE     | shifting in pointer byte or write data
// WR_ACK      | driving ACK for a received byte
// RD_BYTE     | shifting out read data on SDA
// RD_ACK      | sampling the controller's ACK/NACK
// IGNORE      | not addressed or read finished; wait for START/STOP
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .d_i(scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .d_i(sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       ack_q, ack_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            ptr_q     <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= I2C_WRITE;
            first_q   <= 1'b0;
            ack_q     <= I2C_NACK;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            ack_q     <= ack_d;
        end
    end

    // In the ACK states sda_oe_q doubles as the phase bit: low waits for the
    // fall that starts the ACK, high waits for the fall that ends it.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:
                    if (scl_rise && bit_cnt_q == 3'd7)
                        state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:
                    if (scl_fall && sda_oe_q)
                        state_d = (rw_q == I2C_WRITE) ? ST_WR_BYTE : ST_RD_BYTE;
                ST_WR_BYTE:
                    if (scl_rise && bit_cnt_q == 3'd7) state_d = ST_WR_ACK;
                ST_WR_ACK:
                    if (scl_fall && sda_oe_q) state_d = ST_WR_BYTE;
                ST_RD_BYTE:
                    if (scl_fall && bit_cnt_q == 3'd7) state_d = ST_RD_ACK;
                ST_RD_ACK:
                    if (scl_fall) state_d = (ack_q == I2C_ACK) ? ST_RD_BYTE : ST_IGNORE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = we_q ? ptr_q + 8'd1 : ptr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        first_d   = first_q;
        ack_d     = ack_q;
        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_ADDR:
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            busy_d  = (rx_byte[7:1] == DEV_ADDR);
                            rw_d    = rx_byte[0];
                            first_d = 1'b1;
                        end
                    end
                ST_ADDR_ACK, ST_RD_ACK: begin
                    if (state_q == ST_RD_ACK && scl_rise) ack_d = sda_lvl;
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_ADDR_ACK && !sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if ((state_q == ST_ADDR_ACK && rw_q == I2C_READ) ||
                                     (state_q == ST_RD_ACK && ack_q == I2C_ACK)) begin
                            shift_d  = reg_rdata;
                            sda_oe_d = ~reg_rdata[7];
                            ptr_d    = ptr_q + 8'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE:
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (first_q) begin
                                ptr_d   = rx_byte;
                                first_d = 1'b0;
                            end else begin
                                we_d    = 1'b1;
                                wdata_d = rx_byte;
                            end
                        end
                    end
                ST_WR_ACK:
                    if (scl_fall) sda_oe_d = ~sda_oe_q;
                ST_RD_BYTE:
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                default: ;
            endcase
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = ptr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bit-banged I2C controller driving i2c_target_regs, with a write scoreboard.
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, busy;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    // Register bank model: each location reads back as its address inverted.
    assign reg_rdata = reg_addr ^ 8'hFF;

    always #10 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0]      dev;
        logic [7:0]      ptr;
        logic [1:0]      n;
        logic [2:0][7:0] d;
        logic            exp_ack;
        logic [7:0]      ptr_after;
    } wvec_t;

    wr_t sb[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every elapsed cycle is inspected for a write strobe and scored.
    task automatic tick(input int n);
        wr_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (reg_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_we addr=%h data=%h", reg_addr, reg_wdata);
                end else begin
                    e = sb.pop_front();
                    if (reg_addr !== e.addr || reg_wdata !== e.data) begin
                        failures++;
                        $display("FAIL write_sb actual=%h/%h expected=%h/%h",
                                 reg_addr, reg_wdata, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic bus_start();
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_low = 1'b1; tick(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q);
        sda_low = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_low = 1'b0; tick(2*Q);
    endtask

    task automatic bit_out(input logic b);
        tick(Q);
        sda_low = ~b; tick(Q);
        scl = 1'b1;   tick(2*Q);
        scl = 1'b0;
    endtask

    task automatic byte_out(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        tick(Q);
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        ack = sda;      tick(Q);
        scl = 1'b0;
    endtask

    task automatic byte_in(input logic ack_bit, output logic [7:0] data);
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(2*Q);
            scl = 1'b1; tick(Q);
            data[i] = sda; tick(Q);
            scl = 1'b0;
        end
        tick(Q);
        sda_low = (ack_bit == 1'b0); tick(Q);
        scl = 1'b1; tick(2*Q);
        scl = 1'b0;
        sda_low = 1'b0;
    endtask

    wvec_t      vecs[3];
    logic       a;
    logic [7:0] rd;
    logic [7:0] bits;

    initial begin
        vecs[0] = '{dev: 8'h78, ptr: 8'h10, n: 2'd2, d: {8'h00, 8'h55, 8'hAA},
                    exp_ack: 1'b1, ptr_after: 8'h12};
        vecs[1] = '{dev: 8'h7A, ptr: 8'h01, n: 2'd0, d: {8'h00, 8'h00, 8'h00},
                    exp_ack: 1'b0, ptr_after: 8'h12};
        vecs[2] = '{dev: 8'h78, ptr: 8'hFF, n: 2'd3, d: {8'h33, 8'h22, 8'h11},
                    exp_ack: 1'b1, ptr_after: 8'h02};

        repeat (5) @(posedge clk);
        #1;
        chk("rst_addr", reg_addr, 8'h00);
        chk("rst_wdata", reg_wdata, 8'h00);
        chk("rst_we", {7'd0, reg_we}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_sda", {7'd0, sda}, 8'h01);
        rst_n = 1'b1;
        tick(Q);

        foreach (vecs[v]) begin
            bus_start();
            byte_out(vecs[v].dev, a);
            chk($sformatf("v%0d_addr_ack", v), {7'd0, a}, {7'd0, ~vecs[v].exp_ack});
            chk($sformatf("v%0d_busy", v), {7'd0, busy}, {7'd0, vecs[v].exp_ack});
            byte_out(vecs[v].ptr, a);
            chk($sformatf("v%0d_ptr_ack", v), {7'd0, a}, {7'd0, ~vecs[v].exp_ack});
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                if (vecs[v].exp_ack) sb.push_back('{addr: vecs[v].ptr + 8'(k), data: vecs[v].d[k]});
                byte_out(vecs[v].d[k], a);
                chk($sformatf("v%0d_data%0d_ack", v, k), {7'd0, a}, {7'd0, ~vecs[v].exp_ack});
            end
            bus_stop();
            chk($sformatf("v%0d_busy_after_stop", v), {7'd0, busy}, 8'h00);
            chk($sformatf("v%0d_ptr_after", v), reg_addr, vecs[v].ptr_after);
            chk($sformatf("v%0d_writes_drained", v), 8'(sb.size()), 8'h00);
        end

        // Combined read: pointer 0x20, repeated START, two bytes out.
        bus_start();
        byte_out(8'h78, a); chk("rd_addr_w_ack", {7'd0, a}, 8'h00);
        byte_out(8'h20, a); chk("rd_ptr_ack", {7'd0, a}, 8'h00);
        bus_start();
        byte_out(8'h79, a); chk("rd_addr_r_ack", {7'd0, a}, 8'h00);
        chk("rd_busy", {7'd0, busy}, 8'h01);
        byte_in(1'b0, rd);  chk("rd_byte0", rd, 8'hDF);
        byte_in(1'b1, rd);  chk("rd_byte1", rd, 8'hDE);
        tick(Q);
        chk("rd_sda_released", {7'd0, sda}, 8'h01);
        bus_stop();
        chk("rd_ptr_after", reg_addr, 8'h22);
        chk("rd_busy_after_stop", {7'd0, busy}, 8'h00);

        // Abort: STOP after four bits of a data byte.
        bus_start();
        byte_out(8'h78, a);
        byte_out(8'h30, a);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        bus_stop();
        chk("abort_sda", {7'd0, sda}, 8'h01);
        chk("abort_busy", {7'd0, busy}, 8'h00);
        chk("abort_ptr", reg_addr, 8'h30);
        bus_start();
        byte_out(8'h78, a);
        byte_out(8'h40, a);
        sb.push_back('{addr: 8'h40, data: 8'h99});
        byte_out(8'h99, a); chk("post_abort_ack", {7'd0, a}, 8'h00);
        bus_stop();
        chk("post_abort_drained", 8'(sb.size()), 8'h00);
        chk("post_abort_ptr", reg_addr, 8'h41);

        // Async reset while the address ACK is being driven.
        bus_start();
        bits = 8'h78;
        for (int i = 7; i >= 0; i--) bit_out(bits[i]);
        tick(Q);
        sda_low = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        chk("ack_low_before_reset", {7'd0, sda}, 8'h00);
        chk("busy_before_reset", {7'd0, busy}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("reset_sda", {7'd0, sda}, 8'h01);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_addr", reg_addr, 8'h00);
        chk("reset_wdata", reg_wdata, 8'h00);
        chk("reset_we", {7'd0, reg_we}, 8'h00);
        tick(Q);
        rst_n = 1'b1;
        tick(2*Q);
        chk("final_drained", 8'(sb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) responder: the far end of the bus the SSD1306 master drives. It lets an FPGA-side register bank be written and read by any I2C controller using the standard pointer-then-data protocol. It sits between the board's `scl`/`sda` pins and a simple synchronous register port. It runs entirely in the system clock domain and oversamples SCL/SDA, so there is no SCL-clocked logic.

## Interface
Parameters:
- `DEV_ADDR`, 7'h3C: 7-bit target address matched after START.
- `SYNC_STAGES`, 2: synchronizer depth on SCL and SDA inputs.

Ports:
- `clk` in 1: system clock, 50 MHz; must be ≥16× SCL rate.
- `rst_n` in 1: asynchronous, active-low reset.
- `scl` in 1: bus clock; the block never stretches it.
- `sda` inout 1: open-drain data; driven 0 when `sda_oe` is high, else `1'bz`.
- `reg_addr` out 8: current register pointer.
- `reg_wdata` out 8: write data, valid with `reg_we`.
- `reg_we` out 1: one-cycle write strobe.
- `reg_rdata` in 8: read data for `reg_addr`; must be valid one cycle after `reg_addr` changes.
- `busy` out 1: high from an address-matching START to STOP, or to a non-matching repeated START.

## Operation
- **Input conditioning:**
  - SCL and SDA pass through `SYNC_STAGES` flops, then one history flop.
  - This yields `scl_rise`, `scl_fall`, `start_det` (SDA falls while SCL high) and `stop_det` (SDA rises while SCL high).
- **Priority:**
  - `stop_det` forces IDLE and releases SDA.
  - `start_det` forces ADDR from any state, including a repeated START.
  - Both override all other transitions.
- **FSM states:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- **ADDR:**
  - Shift 8 bits MSB-first, one on each `scl_rise`.
  - If the upper 7 bits match `DEV_ADDR`, go to ADDR_ACK and latch R/W.
  - Otherwise go to IGNORE, which idles until START or STOP.
- **ADDR_ACK:**
  - Drive SDA low from the `scl_fall` after bit 8 until the next `scl_fall`.
  - Then go to WR_BYTE if W, or RD_BYTE if R.
- **WR_BYTE / WR_ACK:**
  - The first byte after the address loads the pointer.
  - Each later byte produces `reg_we`, with `reg_addr` equal to the pointer and `reg_wdata` equal to the byte.
  - The pointer increments after each write and wraps 8'hFF→8'h00.
  - Every write byte is ACKed.
- **RD_BYTE:**
  - On entry, load the shift register from `reg_rdata` and increment the pointer.
  - On each `scl_fall`, drive SDA low for 0 bits and release it for 1 bits, MSB-first.
- **RD_ACK:**
  - Release SDA and sample the controller's bit on `scl_rise`.
  - ACK (0): reload and return to RD_BYTE.
  - NACK (1): go to IGNORE.
- **Repeated START:** the pointer persists across it, so write-pointer → Sr → read works.
- **Pointer after STOP:** the pointer also persists across STOP. Only reset clears it.

## Timing
- **Reset values:** `sda_oe`=0 (SDA released), `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, `busy`=0, FSM=IDLE.
- **Detection latency:** `SYNC_STAGES`+1 clk from pin to edge or START/STOP detection.
- **Write strobe:** `reg_we` asserts 1 clk after the `scl_rise` that samples data bit 8.
- **SDA changes** occur only 1 clk after a detected `scl_fall`, never while SCL is high. The only exception is release on STOP or reset.
- **Read data:**
  - The shift-register load samples `reg_rdata` 1 clk after the `scl_fall` that ends the ACK bit.
  - `reg_addr` is already stable at that point.
- **Mid-operation reset** releases SDA immediately, since the reset is asynchronous.

## Structure
- **Package `i2c_pkg`:** FSM state enum; `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1; the R/W encoding (`I2C_WRITE`=0).
- **Sub-module `i2c_sync_edge`:** synchronizer chain plus history flop, with outputs for level, rise and fall. It is instantiated once for SCL and once for SDA. START/STOP decode stays in the top module.

## Test plan
- **Write burst:** START, 0x78, 0x10, 0xAA, 0x55, STOP → ACK on all 4 bytes; `reg_we` pulses twice (addr 0x10 data 0xAA, then 0x11 data 0x55); `busy` drops after STOP.
- **Combined read:** START, 0x78, 0x20, Sr, 0x79; controller ACKs one byte then NACKs the second; `reg_rdata` = addr^8'hFF → bytes 0xDF, 0xDE on SDA; SDA released after the NACK.
- **Address mismatch:** START, 0x7A, 0x01, STOP → no ACK on either byte, no `reg_we`, `busy` stays 0.
- **Pointer wrap:** write pointer 0xFF, then 3 data bytes → writes to 0xFF, 0x00, 0x01.
- **Abort:**
  - STOP inserted after bit 4 of a data byte → FSM returns to IDLE, no `reg_we`, SDA released.
  - A following valid transaction then completes normally.
- **Async reset:** assert `rst_n`=0 during ADDR_ACK while SDA is driven low → `sda_oe`=0 within the same cycle and all outputs return to reset values.
